// File: rtl/iob_delay_line_ctrl_pkg.sv
// Shared types and defaults for the RAM-backed programmable delay line controller.
// The FSM encoding is fixed (IDLE=0, RUN=1, DRAIN=2) so it can be matched in waveforms.
package iob_delay_line_ctrl_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Largest delay a RAM with addr_w address bits can hold (one slot stays free for the write).
    function automatic int dmax(input int addr_w);
        return (1 << addr_w) - 1;
    endfunction

endpackage

// File: rtl/iob_delay_line_ptr.sv
// Wrapping write-pointer counter for the delay line RAM.
// A synchronous clear takes priority over increment; everything freezes when cke_i is low.
module iob_delay_line_ptr #(
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              cke_i,
    input  logic              rst_i,
    input  logic              en_i,
    output logic [ADDR_W-1:0] cnt_o
);

    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (cke_i) begin
            if (rst_i) begin
                cnt_d = '0;
            end else if (en_i) begin
                cnt_d = cnt_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/iob_delay_line_ctrl.sv
// Run-time programmable delay line: sequences an external true-2-port RAM so that
// output sample k equals input sample k-D, with zeros substituted for the first D outputs.
module iob_delay_line_ctrl
    import iob_delay_line_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              cke_i,

    input  logic [ADDR_W:0]   cfg_delay_i,
    input  logic              cfg_start_i,
    input  logic              cfg_stop_i,
    output logic              cfg_err_o,
    output logic              busy_o,
    output logic              primed_o,

    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,

    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,

    output logic              ext_mem_clk_o,
    output logic              ext_mem_w_en_o,
    output logic [ADDR_W-1:0] ext_mem_w_addr_o,
    output logic [DATA_W-1:0] ext_mem_w_data_o,
    output logic              ext_mem_r_en_o,
    output logic [ADDR_W-1:0] ext_mem_r_addr_o,
    input  logic [DATA_W-1:0] ext_mem_r_data_i
);

    localparam int              DMAX     = dmax(ADDR_W);
    localparam logic [ADDR_W:0] DMAX_CFG = (ADDR_W + 1)'(DMAX);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] delay_q, delay_d;
    logic [ADDR_W-1:0] fill_q, fill_d;
    logic              err_q, err_d;
    logic              out_valid_q, out_valid_d;
    logic              zero_q, zero_d;
    logic [DATA_W-1:0] bypass_q, bypass_d;

    logic [ADDR_W-1:0] wptr;
    logic              start_fire;
    logic              in_ready;
    logic              accept;
    logic              mem_acc;
    logic              fill_short;
    logic              bypass_mode;

    // Ready is gated by cke_i so a frozen controller never claims a sample it cannot store.
    assign start_fire  = cke_i & (state_q == ST_IDLE) & cfg_start_i;
    assign in_ready    = cke_i & (state_q == ST_RUN) & (~out_valid_q | out_ready_i);
    assign accept      = in_valid_i & in_ready;
    assign bypass_mode = (delay_q == '0);
    assign mem_acc     = accept & ~bypass_mode;
    assign fill_short  = (fill_q < delay_q);

    iob_delay_line_ptr #(
        .ADDR_W (ADDR_W)
    ) u_wptr (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .cke_i    (cke_i),
        .rst_i    (start_fire),
        .en_i     (mem_acc),
        .cnt_o    (wptr)
    );

    always_comb begin
        state_d     = state_q;
        delay_d     = delay_q;
        fill_d      = fill_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        zero_d      = zero_q;
        bypass_d    = bypass_q;

        if (cke_i) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (cfg_start_i) begin
                        state_d = ST_RUN;
                        fill_d  = '0;
                        if (cfg_delay_i > DMAX_CFG) begin
                            delay_d = ADDR_W'(DMAX);
                            err_d   = 1'b1;
                        end else begin
                            delay_d = cfg_delay_i[ADDR_W-1:0];
                            err_d   = 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    if (cfg_stop_i) begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!out_valid_q) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            // Until D samples have been written the read slot holds stale data, so mask it.
            if (accept) begin
                out_valid_d = 1'b1;
                zero_d      = fill_short;
                if (fill_short) begin
                    fill_d = fill_q + ADDR_W'(1);
                end
                if (bypass_mode) begin
                    bypass_d = in_data_i;
                end
            end else if (out_ready_i) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q     <= ST_IDLE;
            delay_q     <= '0;
            fill_q      <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            zero_q      <= 1'b0;
            bypass_q    <= '0;
        end else begin
            state_q     <= state_d;
            delay_q     <= delay_d;
            fill_q      <= fill_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            zero_q      <= zero_d;
            bypass_q    <= bypass_d;
        end
    end

    // Read slot trails the write slot by D; with 1 <= D <= DMAX the two never collide.
    assign ext_mem_clk_o    = clk_i;
    assign ext_mem_w_en_o   = mem_acc;
    assign ext_mem_w_addr_o = wptr;
    assign ext_mem_w_data_o = in_data_i;
    assign ext_mem_r_en_o   = mem_acc;
    assign ext_mem_r_addr_o = wptr - delay_q;

    assign out_data_o  = zero_q      ? '0       :
                         bypass_mode ? bypass_q : ext_mem_r_data_i;
    assign out_valid_o = out_valid_q;
    assign in_ready_o  = in_ready;
    assign cfg_err_o   = err_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign primed_o    = (fill_q == delay_q);

endmodule

// File: tb/tb_iob_delay_line_ctrl.sv
// Bench for iob_delay_line_ctrl: external RAM model, delay-line reference model with a
// per-cycle compare process, and directed scenarios with literal expectations.
module tb_iob_delay_line_ctrl;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;

    logic              clk_i       = 1'b0;
    logic              arst_n_i    = 1'b1;
    logic              cke_i       = 1'b1;
    logic [ADDR_W:0]   cfg_delay_i = '0;
    logic              cfg_start_i = 1'b0;
    logic              cfg_stop_i  = 1'b0;
    logic              in_valid_i  = 1'b0;
    logic [DATA_W-1:0] in_data_i   = '0;
    logic              out_ready_i = 1'b1;

    logic              cfg_err_o, busy_o, primed_o, in_ready_o, out_valid_o;
    logic [DATA_W-1:0] out_data_o;
    logic              ext_mem_clk_o, ext_mem_w_en_o, ext_mem_r_en_o;
    logic [ADDR_W-1:0] ext_mem_w_addr_o, ext_mem_r_addr_o;
    logic [DATA_W-1:0] ext_mem_w_data_o;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] mem [16];

    int n_cmp = 0;
    int n_err = 0;
    int ready_mode = 0;
    int cyc = 0;
    logic [7:0] got[$];

    // reference model state
    bit         m_run, m_drain, m_valid, m_err;
    int         m_d, m_k;
    logic [7:0] m_data;
    logic [7:0] hist[$];
    bit         er, acc, exp_w, old_valid;

    iob_delay_line_ctrl #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk_i            (clk_i),
        .arst_n_i         (arst_n_i),
        .cke_i            (cke_i),
        .cfg_delay_i      (cfg_delay_i),
        .cfg_start_i      (cfg_start_i),
        .cfg_stop_i       (cfg_stop_i),
        .cfg_err_o        (cfg_err_o),
        .busy_o           (busy_o),
        .primed_o         (primed_o),
        .in_valid_i       (in_valid_i),
        .in_ready_o       (in_ready_o),
        .in_data_i        (in_data_i),
        .out_valid_o      (out_valid_o),
        .out_ready_i      (out_ready_i),
        .out_data_o       (out_data_o),
        .ext_mem_clk_o    (ext_mem_clk_o),
        .ext_mem_w_en_o   (ext_mem_w_en_o),
        .ext_mem_w_addr_o (ext_mem_w_addr_o),
        .ext_mem_w_data_o (ext_mem_w_data_o),
        .ext_mem_r_en_o   (ext_mem_r_en_o),
        .ext_mem_r_addr_o (ext_mem_r_addr_o),
        .ext_mem_r_data_i (mem_rdata)
    );

    always #5 clk_i = ~clk_i;

    // external true-2-port RAM: registered read, holds when not enabled
    always @(posedge ext_mem_clk_o) begin
        if (ext_mem_w_en_o) mem[ext_mem_w_addr_o] <= ext_mem_w_data_o;
        if (ext_mem_r_en_o) mem_rdata <= mem[ext_mem_r_addr_o];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // downstream ready pattern: 0 always ready, 1 ready one cycle in three, 2 never ready
    initial forever begin
        @(posedge clk_i);
        #2;
        cyc++;
        out_ready_i = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? (cyc % 3 == 0) : 1'b0;
    end

    // reference model and per-cycle compare
    initial forever begin
        @(negedge clk_i);
        if (!arst_n_i) begin
            m_run = 0; m_drain = 0; m_valid = 0; m_err = 0;
            m_d = 0; m_k = 0; m_data = '0; hist.delete();
        end else begin
            er    = cke_i && m_run && (!m_valid || out_ready_i);
            acc   = er && in_valid_i;
            exp_w = acc && (m_d != 0);
            chk("in_ready", 32'(in_ready_o), 32'(er));
            chk("out_valid", 32'(out_valid_o), 32'(m_valid));
            if (m_valid) chk("out_data", 32'(out_data_o), 32'(m_data));
            chk("busy", 32'(busy_o), 32'(m_run || m_drain));
            chk("cfg_err", 32'(cfg_err_o), 32'(m_err));
            chk("primed", 32'(primed_o), 32'(m_k >= m_d));
            chk("w_en", 32'(ext_mem_w_en_o), 32'(exp_w));
            chk("r_en", 32'(ext_mem_r_en_o), 32'(exp_w));
            if (exp_w) begin
                chk("w_addr", 32'(ext_mem_w_addr_o), m_k % 16);
                chk("r_addr", 32'(ext_mem_r_addr_o), (m_k - m_d + 16) % 16);
                chk("w_data", 32'(ext_mem_w_data_o), 32'(in_data_i));
            end
            if (cke_i && out_valid_o && out_ready_i) got.push_back(out_data_o);
            if (cke_i) begin
                old_valid = m_valid;
                if (!m_run && !m_drain) begin
                    if (cfg_start_i) begin
                        m_run = 1;
                        m_err = (cfg_delay_i > 15);
                        m_d   = (cfg_delay_i > 15) ? 15 : int'(cfg_delay_i);
                        m_k   = 0;
                        hist.delete();
                    end
                end else if (m_run) begin
                    if (cfg_stop_i) begin
                        m_run = 0; m_drain = 1;
                    end
                end else if (!old_valid) begin
                    m_drain = 0;
                end
                if (acc) begin
                    hist.push_back(in_data_i);
                    m_data  = (m_k < m_d) ? 8'h00 : hist[m_k - m_d];
                    m_k++;
                    m_valid = 1;
                end else if (out_ready_i) begin
                    m_valid = 0;
                end
            end
        end
    end

    task automatic start_run(input logic [ADDR_W:0] d);
        cfg_delay_i = d;
        cfg_start_i = 1'b1;
        @(posedge clk_i); #1;
        cfg_start_i = 1'b0;
    endtask

    task automatic stop_run();
        cfg_stop_i = 1'b1;
        @(posedge clk_i); #1;
        cfg_stop_i = 1'b0;
    endtask

    task automatic push(input logic [7:0] v);
        int n = 0;
        in_valid_i = 1'b1;
        in_data_i  = v;
        @(negedge clk_i);
        while (!in_ready_o && n < 50) begin
            n++;
            @(negedge clk_i);
        end
        chk("push_ready", 32'(in_ready_o), 1);
        @(posedge clk_i); #1;
    endtask

    task automatic drain(input int n);
        in_valid_i = 1'b0;
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_o && n < 50) begin
            n++;
            @(posedge clk_i); #1;
        end
        chk("idle_reached", 32'(busy_o), 0);
    endtask

    task automatic got_at(input string nm, input int idx, input logic [7:0] exp);
        if (idx < got.size()) chk(nm, 32'(got[idx]), 32'(exp));
        else chk(nm, 32'hFFFF_FFFF, 32'(exp));
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid_o), 0);
        chk({tag, "_busy"}, 32'(busy_o), 0);
        chk({tag, "_cfg_err"}, 32'(cfg_err_o), 0);
        chk({tag, "_in_ready"}, 32'(in_ready_o), 0);
        chk({tag, "_w_en"}, 32'(ext_mem_w_en_o), 0);
        chk({tag, "_r_en"}, 32'(ext_mem_r_en_o), 0);
        chk({tag, "_out_data"}, 32'(out_data_o), 0);
        chk({tag, "_primed"}, 32'(primed_o), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got %0d expected 0 pending", 1);
        $fatal(1, "watchdog");
    end

    initial begin
        #2 arst_n_i = 1'b0;
        #1 reset_checks("rst");
        repeat (2) @(posedge clk_i);
        #1 arst_n_i = 1'b1;

        // D=10, full-rate, with a short clock-enable freeze mid-stream
        got.delete();
        start_run(5'd10);
        for (int i = 0; i < 32; i++) begin
            push(8'(i));
            if (i == 8) chk("primed_after9", 32'(primed_o), 0);
            if (i == 9) chk("primed_after10", 32'(primed_o), 1);
            if (i == 15) begin
                in_valid_i = 1'b0;
                cke_i = 1'b0;
                repeat (3) @(posedge clk_i);
                #1 cke_i = 1'b1;
            end
        end
        drain(4);
        chk("t1_count", got.size(), 32);
        got_at("t1_out9", 9, 8'd0);
        got_at("t1_out11", 11, 8'd1);
        got_at("t1_out20", 20, 8'd10);
        got_at("t1_out31", 31, 8'd21);
        stop_run();
        wait_idle();

        // D=10 with downstream ready one cycle in three
        got.delete();
        ready_mode = 1;
        start_run(5'd10);
        for (int i = 0; i < 32; i++) push(8'(i));
        drain(2);
        ready_mode = 0;
        drain(4);
        chk("t2_count", got.size(), 32);
        got_at("t2_out9", 9, 8'd0);
        got_at("t2_out11", 11, 8'd1);
        got_at("t2_out31", 31, 8'd21);
        stop_run();
        wait_idle();

        // D=0 bypass: one-cycle latency, RAM untouched
        got.delete();
        start_run(5'd0);
        push(8'd5);
        chk("t3_lat_valid", 32'(out_valid_o), 1);
        chk("t3_lat_data", 32'(out_data_o), 5);
        push(8'd6);
        push(8'd7);
        drain(3);
        chk("t3_count", got.size(), 3);
        got_at("t3_out0", 0, 8'd5);
        got_at("t3_out2", 2, 8'd7);
        stop_run();
        wait_idle();

        // out-of-range delay clamps to 15 and flags the error
        got.delete();
        start_run(5'd16);
        chk("t4_err", 32'(cfg_err_o), 1);
        for (int i = 0; i < 20; i++) push(8'(i));
        drain(4);
        chk("t4_count", got.size(), 20);
        got_at("t4_out14", 14, 8'd0);
        got_at("t4_out15", 15, 8'd0);
        got_at("t4_out16", 16, 8'd1);
        got_at("t4_out19", 19, 8'd4);
        stop_run();
        wait_idle();

        // async reset mid-stream, then a clean restart
        got.delete();
        start_run(5'd10);
        for (int i = 0; i < 6; i++) push(8'(i));
        in_valid_i = 1'b0;
        #2 arst_n_i = 1'b0;
        #1 reset_checks("midrst");
        @(posedge clk_i);
        #1 arst_n_i = 1'b1;
        got.delete();
        start_run(5'd10);
        for (int i = 0; i < 12; i++) push(8'(i));
        drain(4);
        chk("t6_count", got.size(), 12);
        got_at("t6_out9", 9, 8'd0);
        got_at("t6_out11", 11, 8'd1);
        stop_run();
        wait_idle();

        // stop with an output pending, drain, then restart over stale RAM
        got.delete();
        start_run(5'd4);
        for (int i = 0; i < 12; i++) push(8'(i));
        in_valid_i = 1'b0;
        ready_mode = 2;
        stop_run();
        chk("t5_ready_drop", 32'(in_ready_o), 0);
        chk("t5_busy_drain", 32'(busy_o), 1);
        drain(2);
        chk("t5_held_valid", 32'(out_valid_o), 1);
        chk("t5_held_data", 32'(out_data_o), 7);
        ready_mode = 0;
        drain(2);
        wait_idle();
        chk("t5_count", got.size(), 12);
        got_at("t5_out3", 3, 8'd0);
        got_at("t5_out11", 11, 8'd7);
        got.delete();
        start_run(5'd4);
        for (int i = 0; i < 6; i++) push(8'(100 + i));
        drain(4);
        got_at("t5r_out0", 0, 8'd0);
        got_at("t5r_out3", 3, 8'd0);
        got_at("t5r_out4", 4, 8'd100);
        got_at("t5r_out5", 5, 8'd101);
        stop_run();
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
